// File: rtl/booth_controller.sv
// Sequencing FSM for a radix-2 Booth multiplier datapath.
// Walks LOAD -> (EVAL -> SHIFT) x N_BITS -> DONE for each multiplication
// and exposes a start/busy/done handshake plus the iteration index.
module booth_controller #(
    parameter int N_BITS = 4,
    parameter int CNT_W  = $clog2(N_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Q0,
    input  logic             Q1,
    output logic             LoadA,
    output logic             LoadB,
    output logic             rs,
    output logic             LoadAdd,
    output logic             SEL,
    output logic             Shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BITS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_q;
    logic             shift_q;
    logic             busy_q;
    logic             done_q;

    // State, iteration counter and the Moore outputs, registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state  <= LOAD;
                        load_q <= 1'b1;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                LOAD: begin
                    state  <= EVAL;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                end
                EVAL: begin
                    state   <= SHIFT;
                    shift_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    if (cnt == LAST_ITER) begin
                        // iter must read 0 again while DONE is presented
                        state  <= DONE;
                        cnt    <= '0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= EVAL;
                        cnt    <= cnt + 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Booth pair decode in EVAL: 10 subtracts M, 01 adds M, 00/11 do nothing
    always_comb begin
        LoadAdd = 1'b0;
        SEL     = 1'b0;
        if (state == EVAL) begin
            LoadAdd = Q0 ^ Q1;
            SEL     = Q0 & ~Q1;
        end
    end

    assign LoadA = load_q;
    assign LoadB = load_q;
    assign rs    = load_q;
    assign Shift = shift_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign iter  = cnt;

endmodule

// File: tb/tb_booth_controller.sv
// Self-checking bench for booth_controller: a cycle-timeline reference model
// predicts every control output; a small Booth datapath checks products.
module tb_booth_controller;

    localparam int N = 4;
    localparam int LAT = 2 * N + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       Q0, Q1;
    logic       LoadA, LoadB, rs, LoadAdd, SEL, Shift, busy, done;
    logic [1:0] iter;

    // forced Booth pair or the pair from the datapath below
    logic       use_force = 1'b1;
    logic       fq0 = 1'b0, fq1 = 1'b0;

    // Booth datapath driven by the controller
    logic [3:0] opa = '0, opb = '0;
    logic [3:0] m, hq, lq;
    logic       qm1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = -1000;

    logic [9:0] obs;

    booth_controller #(.N_BITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .Q0(Q0), .Q1(Q1),
        .LoadA(LoadA), .LoadB(LoadB), .rs(rs), .LoadAdd(LoadAdd),
        .SEL(SEL), .Shift(Shift), .busy(busy), .done(done), .iter(iter)
    );

    always #5 clk = ~clk;

    assign Q0  = use_force ? fq0 : lq[0];
    assign Q1  = use_force ? fq1 : qm1;
    assign obs = {LoadA, LoadB, rs, LoadAdd, SEL, Shift, busy, done, iter};

    always @(posedge clk) begin
        if (LoadA) m <= opa;
        if (LoadB) lq <= opb;
        if (rs) begin
            hq  <= '0;
            qm1 <= 1'b0;
        end
        if (LoadAdd) hq <= SEL ? hq - m : hq + m;
        if (Shift) {hq, lq, qm1} <= {hq[3], hq, lq};
    end

    // Expected {LoadA,LoadB,rs,LoadAdd,SEL,Shift,busy,done,iter} at a given
    // number of cycles after start was accepted
    function automatic logic [9:0] model(input int ph, input logic q0, input logic q1);
        logic [9:0] v;
        v = '0;
        if (ph == 1) begin
            v[9] = 1'b1; v[8] = 1'b1; v[7] = 1'b1; v[3] = 1'b1;
        end else if (ph >= 2 && ph <= 2 * N && (ph % 2) == 0) begin
            v[6]   = q0 ^ q1;
            v[5]   = q0 & ~q1;
            v[3]   = 1'b1;
            v[1:0] = 2'((ph - 2) / 2);
        end else if (ph >= 3 && ph <= 2 * N + 1) begin
            v[4]   = 1'b1;
            v[3]   = 1'b1;
            v[1:0] = 2'((ph - 3) / 2);
        end else if (ph == LAT) begin
            v[2] = 1'b1;
        end
        return v;
    endfunction

    // Advance one cycle: drive this cycle's inputs, sample mid-cycle and
    // return the model's expectation; then advance the model
    task automatic tick(input logic st, input logic r, input logic f0, input logic f1,
                        output logic [9:0] exp);
        int ph;
        @(posedge clk);
        cyc++;
        #1;
        start = st;
        rst   = r;
        fq0   = f0;
        fq1   = f1;
        @(negedge clk);
        ph  = cyc - t0;
        exp = model(ph, Q0, Q1);
        if (r) t0 = -1000;
        else if ((ph <= 0 || ph > LAT) && st) t0 = cyc;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        int s, dcyc;
        use_force = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, e);
            checks++;
            if (obs !== 10'b0) begin
                errors++;
                $display("FAIL reset_init cyc=%0d got=%b exp=%b", cyc, obs, 10'b0);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, e);
        tick(1'b1, 1'b0, 1'b0, 1'b0, e);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_prerun cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, e);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, e);
            checks++;
            if (obs !== 10'b0) begin
                errors++;
                $display("FAIL reset_abort cyc=%0d got=%b exp=%b", cyc, obs, 10'b0);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, e);
        s = cyc;
        dcyc = -1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, e);
            if (done === 1'b1 && dcyc < 0) dcyc = cyc;
        end
        checks++;
        if (dcyc - s !== LAT) begin
            errors++;
            $display("FAIL reset_restart_latency got=%0d exp=%0d", dcyc - s, LAT);
        end
    endtask

    task automatic test_timing_00();
        logic [9:0] e;
        int nshift, nadd, nbusy, ndone;
        use_force = 1'b1;
        nshift = 0; nadd = 0; nbusy = 0; ndone = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, e);
        for (int i = 0; i < LAT + 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timing00 phase=%0d got=%b exp=%b", i + 1, obs, e);
            end
            nshift += int'(Shift);
            nadd   += int'(LoadAdd);
            nbusy  += int'(busy);
            ndone  += int'(done);
        end
        checks++;
        if ({nshift, nadd, nbusy, ndone} !== {N, 0, 2 * N + 1, 1}) begin
            errors++;
            $display("FAIL timing00_counts got=%0d/%0d/%0d/%0d exp=%0d/0/%0d/1",
                     nshift, nadd, nbusy, ndone, N, 2 * N + 1);
        end
    endtask

    task automatic test_eval_decode();
        logic [9:0] e;
        logic [1:0] pat [4];
        logic [1:0] q;
        pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b00;
        use_force = 1'b1;
        for (int p = 0; p < 7; p++) begin
            q = (p < 4) ? pat[p] : 2'($urandom_range(0, 3));
            tick(1'b1, 1'b0, q[1], q[0], e);
            for (int i = 0; i < LAT + 1; i++) begin
                if (p >= 4) q = 2'($urandom_range(0, 3));
                tick(1'b0, 1'b0, q[1], q[0], e);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL eval_decode q=%b phase=%0d got=%b exp=%b",
                             q, i + 1, obs, e);
                end
            end
        end
    endtask

    task automatic test_products();
        logic [9:0] e;
        logic [3:0] av [3];
        logic [3:0] bv [3];
        logic [7:0] want;
        int prod, ndone;
        av[0] = 4'd3;    bv[0] = 4'd2;
        av[1] = 4'b1101; bv[1] = 4'd5;
        av[2] = 4'd7;    bv[2] = 4'b1001;
        use_force = 1'b0;
        for (int r = 0; r < 23; r++) begin
            if (r < 3) begin
                opa = av[r];
                opb = bv[r];
            end else begin
                opa = 4'($urandom_range(0, 14) + 9);
                opb = 4'($urandom_range(0, 15));
            end
            prod = $signed(opa) * $signed(opb);
            want = prod[7:0];
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                tick(1'b0, 1'b0, 1'b0, 1'b0, e);
            tick(1'b1, 1'b0, 1'b0, 1'b0, e);
            ndone = 0;
            for (int i = 0; i < LAT; i++) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0, e);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL product_ctrl a=%h b=%h phase=%0d got=%b exp=%b",
                             opa, opb, i + 1, obs, e);
                end
                if (e[2]) begin
                    ndone++;
                    checks++;
                    if ({hq, lq} !== want) begin
                        errors++;
                        $display("FAIL product a=%h b=%h got=%h exp=%h",
                                 opa, opb, {hq, lq}, want);
                    end
                end
            end
            checks++;
            if (ndone !== 1) begin
                errors++;
                $display("FAIL product_done_seen a=%h b=%h got=%0d exp=1", opa, opb, ndone);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        int s, nload, ndone, ld [3];
        use_force = 1'b0;
        opa = 4'd5;
        opb = 4'd3;
        tick(1'b0, 1'b0, 1'b0, 1'b0, e);
        s = cyc + 1;
        nload = 0;
        ndone = 0;
        for (int i = 0; i < 36; i++) begin
            tick((i < 30) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc - s, obs, e);
            end
            if (LoadA === 1'b1) begin
                if (nload < 3) ld[nload] = cyc - s;
                nload++;
            end
            ndone += int'(done === 1'b1);
        end
        checks++;
        if (nload !== 3 || ld[0] !== 1 || ld[1] !== 12 || ld[2] !== 23) begin
            errors++;
            $display("FAIL b2b_loads got=%0d@%0d,%0d,%0d exp=3@1,12,23",
                     nload, ld[0], ld[1], ld[2]);
        end
        checks++;
        if (ndone !== 3) begin
            errors++;
            $display("FAIL b2b_dones got=%0d exp=3", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_timing_00();
        test_eval_decode();
        test_products();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
